// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial WIDTH-bit adder sequencer.
// One full-add slice (two half-add stages plus an OR for the carry) is
// reused over the operand bits, LSB first, one bit per clock.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// RUN   | one operand bit added per edge; busy asserted
// DONE  | single-cycle completion pulse; sum/cout already loaded
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res;
   logic [WIDTH-1:0] res_nxt;
   logic             c;
   logic [CW-1:0]    cnt;
   logic             last_bit;

   logic ha1_s;
   logic ha1_c;
   logic ha2_s;
   logic ha2_c;
   logic c_nxt;

   // full add built from two half-add stages; the carries are never both set
   assign ha1_s = a_sh[0] ^ b_sh[0];
   assign ha1_c = a_sh[0] & b_sh[0];
   assign ha2_s = ha1_s ^ c;
   assign ha2_c = ha1_s & c;
   assign c_nxt = ha1_c | ha2_c;

   // the new sum bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB
   generate
      if (WIDTH == 1) begin : g_res_w1
         assign res_nxt = ha2_s;
      end else begin : g_res_wn
         assign res_nxt = {ha2_s, res[WIDTH-1:1]};
      end
   endgenerate

   assign last_bit = (cnt == CW'(WIDTH - 1));

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state decode; start only matters in IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (last_bit) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // operand capture, bit-serial datapath and result load at the final bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh <= '0;
         b_sh <= '0;
         res  <= '0;
         c    <= 1'b0;
         cnt  <= '0;
         sum  <= '0;
         cout <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  a_sh <= a;
                  b_sh <= b;
                  c    <= cin;
                  cnt  <= '0;
               end
            end
            RUN: begin
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               c    <= c_nxt;
               res  <= res_nxt;
               cnt  <= cnt + CW'(1);
               if (last_bit) begin
                  sum  <= res_nxt;
                  cout <= c_nxt;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

   typedef struct {
      logic [7:0] s;
      logic       co;
      logic       period_chk;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic       busy;
   logic       done;
   logic [7:0] sum;
   logic       cout;

   logic       start1;
   logic [0:0] a1;
   logic [0:0] b1;
   logic       cin1;
   logic       busy1;
   logic       done1;
   logic [0:0] sum1;
   logic       cout1;

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t q[$];
   int   ncyc = 0;
   int   run_len = 0;
   int   last_done = -100;

   serial_add_ctrl #(.WIDTH(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
      .busy(busy), .done(done), .sum(sum), .cout(cout)
   );

   serial_add_ctrl #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // scoreboard monitor: pops an expectation on every done pulse
   always @(negedge clk) begin
      exp_t e;
      ncyc++;
      if (!rst_n) begin
         run_len = 0;
      end else if (busy) begin
         run_len++;
      end else if (done) begin
         if (q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = q.pop_front();
            chk("sum", {24'd0, sum}, {24'd0, e.s});
            chk("cout", {31'd0, cout}, {31'd0, e.co});
            chk("busy_cycles", run_len, 8);
            if (e.period_chk) chk("done_period", ncyc - last_done, 10);
         end
         last_done = ncyc;
         run_len = 0;
      end
   end

   task automatic issue(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                        input logic push, input logic [7:0] es, input logic eco);
      exp_t e;
      @(negedge clk);
      a = av; b = bv; cin = cv; start = 1'b1;
      @(posedge clk);
      if (push) begin
         e.s = es; e.co = eco; e.period_chk = 1'b0;
         q.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done();
      bit seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1;
            break;
         end
      end
      if (!seen) chk("done_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end, expected finish");
      $fatal(1);
   end

   initial begin
      exp_t e;
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
      #12;
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_done", {31'd0, done}, 0);
      chk("rst_sum", {24'd0, sum}, 0);
      chk("rst_cout", {31'd0, cout}, 0);
      chk("rst_busy1", {31'd0, busy1}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 1: FF + 01
      issue(8'hFF, 8'h01, 1'b0, 1'b1, 8'h00, 1'b1);
      chk("t1_busy_after_accept", {31'd0, busy}, 1);
      wait_done();

      // 2: A5 + 5A + 1, then 0 + 0 with previous result held during RUN
      issue(8'hA5, 8'h5A, 1'b1, 1'b1, 8'h00, 1'b1);
      wait_done();
      issue(8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
      @(negedge clk);
      chk("t2_hold_sum", {24'd0, sum}, 0);
      chk("t2_hold_cout", {31'd0, cout}, 1);
      wait_done();

      // 3: start and operand changes during RUN must be ignored
      issue(8'h3C, 8'h0F, 1'b0, 1'b1, 8'h4B, 1'b0);
      @(negedge clk);
      start = 1'b1; a = 8'hFF; b = 8'hFF;
      @(negedge clk);
      start = 1'b0;
      wait_done();
      repeat (12) @(negedge clk);
      chk("t3_idle_after", {31'd0, busy}, 0);

      // 4: async reset at the 4th RUN edge aborts the operation
      issue(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t4_busy", {31'd0, busy}, 0);
      chk("t4_done", {31'd0, done}, 0);
      chk("t4_sum", {24'd0, sum}, 0);
      chk("t4_cout", {31'd0, cout}, 0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("t4_stays_idle", {31'd0, busy}, 0);
      chk("t4_sum_after", {24'd0, sum}, 0);

      // 5: start held high -> done every WIDTH+2 cycles
      e.s = 8'h02; e.co = 1'b0; e.period_chk = 1'b0;
      q.push_back(e);
      e.period_chk = 1'b1;
      q.push_back(e);
      q.push_back(e);
      @(negedge clk);
      a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
      wait_done();
      wait_done();
      wait_done();
      start = 1'b0;
      repeat (14) @(negedge clk);
      chk("t5_idle_after", {31'd0, busy}, 0);
      chk("t5_queue_empty", q.size(), 0);

      // 6: WIDTH=1, 1 + 1 + 1
      @(negedge clk);
      a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      chk("w1_busy", {31'd0, busy1}, 1);
      chk("w1_done_early", {31'd0, done1}, 0);
      @(negedge clk);
      chk("w1_done", {31'd0, done1}, 1);
      chk("w1_sum", {31'd0, sum1}, 1);
      chk("w1_cout", {31'd0, cout1}, 1);
      @(negedge clk);
      chk("w1_done_gone", {31'd0, done1}, 0);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial N-bit adder sequencer. It time-multiplexes a single 1-bit full-add datapath, built from two half-add stages plus an OR for the carry, over WIDTH operand bits, one bit per clock. It owns operand capture, bit shifting, the carry flop, the bit counter and the start/busy/done handshake. It lets the team reuse the half-adder cell for multi-bit arithmetic where area matters more than latency.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 1..32.

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  operand A; captured on the accepting edge
b  input  WIDTH  operand B; captured on the accepting edge
cin  input  1  carry-in; captured on the accepting edge
busy  output  1  high while an addition is in progress (RUN state)
done  output  1  single-cycle completion pulse (DONE state)
sum  output  WIDTH  registered result; updated only at completion
cout  output  1  registered final carry; updated only at completion

Behaviour:
- Single clock domain: clk. Reset is asynchronous, active-low (rst_n).
- While rst_n=0: state=IDLE; busy=0; done=0; sum=0; cout=0; shift registers, carry flop and counter cleared.
- FSM states and transitions:
  - IDLE: start=1 at a rising edge (E0) captures a, b and cin into the shift registers and carry flop, clears the counter and moves to RUN. start=0 keeps the FSM in IDLE.
  - RUN: on each edge E1..E_WIDTH:
    - s = a_sh[0] ^ b_sh[0] ^ c.
    - c <= (a_sh[0] & b_sh[0]) | (c & (a_sh[0] ^ b_sh[0])).
    - a_sh and b_sh shift right by 1; s shifts into the MSB of the internal result register; counter increments.
    - When the counter reaches WIDTH-1 at an edge, that same edge (E_WIDTH) loads sum <= final result and cout <= final carry, and moves to DONE.
  - DONE: lasts exactly one cycle, then returns unconditionally to IDLE at E_WIDTH+1.
- Outputs decode from state: busy=1 only in RUN; done=1 only in DONE.
- Latency: done is high in the cycle between E_WIDTH and E_WIDTH+1. This is WIDTH edges after the accepting edge. Throughput is one addition per WIDTH+2 cycles.
- sum and cout hold the previous result during RUN. They remain stable after done until the next completion.
- start is ignored in RUN and DONE; there is no queueing. start held high continuously restarts in IDLE on every pass, giving a period of WIDTH+2.
- Changes on a, b or cin after E0 have no effect on the operation in progress.
- Counter width is clog2(WIDTH)+1 bits. The counter does not wrap within an operation.
- WIDTH=1: RUN lasts one edge; done appears in the cycle after E1.
- rst_n asserted mid-RUN: operation aborted immediately. No done is produced, and sum/cout return to 0. After rst_n deasserts, the block sits in IDLE awaiting start.
- No X on outputs after reset. All outputs are registered or decoded from registered state only, with no combinational path from inputs to outputs.

Test Plan:
1. WIDTH=8, a=8'hFF, b=8'h01, cin=0, 1-cycle start pulse -> busy=1 for 8 cycles; done pulses once 8 edges after the accepting edge; sum=8'h00, cout=1.
2. a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1. Then a=8'h00, b=8'h00, cin=0 -> sum=8'h00, cout=0, with the previous result held during RUN.
3. a=8'h3C, b=8'h0F, cin=0; during RUN pulse start and change a and b to 8'hFF -> second start ignored; sum=8'h4B, cout=0; exactly one done pulse.
4. Drive rst_n low for 1 cycle at the 4th RUN edge of a=8'h80, b=8'h80 -> busy, done, sum and cout go to 0 immediately (asynchronously), no done follows, and the FSM idles until the next start.
5. start held high continuously with a=8'h01, b=8'h01, cin=0 -> done pulses repeat every 10 cycles; sum=8'h02 each time.
6. Instantiate WIDTH=1, a=1, b=1, cin=1 -> done appears in the cycle after E1; sum=1, cout=1.
